// File: rtl/cram_config_ctrl_if.sv
// Host, chain and fabric signals of the CRAM configuration sequencer.
// The master modport is the host side and the slave modport is the controller side.
interface cram_config_ctrl_if #(
  parameter int WORD_W = 32
);
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              chain_en;
  logic              chain_data_out;
  logic              chain_data_in;
  logic [WORD_W-1:0] rb_word;
  logic              rb_valid;
  logic              fabric_en;
  logic              fabric_nrst;
  logic              busy;
  logic              done;
  logic              aborted;

  modport master (
    output start, abort, word_data, word_valid, chain_data_in,
    input  word_ready, chain_en, chain_data_out, rb_word, rb_valid,
           fabric_en, fabric_nrst, busy, done, aborted
  );

  modport slave (
    input  start, abort, word_data, word_valid, chain_data_in,
    output word_ready, chain_en, chain_data_out, rb_word, rb_valid,
           fabric_en, fabric_nrst, busy, done, aborted
  );
endinterface

// File: rtl/cram_config_ctrl.sv
// Serialises host bitstream words LSB-first into a daisy-chained CRAM column,
// captures readback words from the chain tail, and sequences fabric enable/reset.
module cram_config_ctrl #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int RST_HOLD  = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  cram_config_ctrl_if.slave     bus
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int SH_W  = $clog2(WORD_W + 1);
  localparam int RB_W  = $clog2(WORD_W);
  localparam int ST_W  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
  localparam logic [SH_W-1:0]  FULL_CNT = SH_W'(WORD_W);
  localparam logic [RB_W-1:0]  RB_LAST  = RB_W'(WORD_W - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_DONE
  } state_e;

  state_e            state_q,    state_d;
  logic [WORD_W-1:0] sh_q,       sh_d;
  logic [SH_W-1:0]   sh_cnt_q,   sh_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [WORD_W-2:0] rb_sh_q,    rb_sh_d;
  logic [RB_W-1:0]   rb_cnt_q,   rb_cnt_d;
  logic [WORD_W-1:0] rb_word_q,  rb_word_d;
  logic              rb_valid_q, rb_valid_d;
  logic [ST_W-1:0]   settle_q,   settle_d;
  logic              aborted_q,  aborted_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              fab_en_q,   fab_en_d;
  logic              fab_nrst_q, fab_nrst_d;

  logic in_load;
  logic shifting;
  logic last_bit;
  logic word_ready;
  logic accept;

  // The last bit blocks word_ready so a held word_valid cannot sneak in an extra word.
  always_comb begin
    in_load    = (state_q == S_LOAD);
    shifting   = in_load && (sh_cnt_q != '0);
    last_bit   = shifting && (bit_cnt_q == LAST_BIT);
    word_ready = in_load && (sh_cnt_q <= SH_W'(1)) && !last_bit;
    accept     = word_ready && bus.word_valid;
  end

  assign bus.word_ready     = word_ready;
  assign bus.chain_en       = shifting;
  assign bus.chain_data_out = shifting & sh_q[0];
  assign bus.rb_word        = rb_word_q;
  assign bus.rb_valid       = rb_valid_q;
  assign bus.fabric_en      = fab_en_q;
  assign bus.fabric_nrst    = fab_nrst_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.aborted        = aborted_q;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    sh_cnt_d   = sh_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    rb_sh_d    = rb_sh_q;
    rb_cnt_d   = rb_cnt_q;
    rb_word_d  = rb_word_q;
    rb_valid_d = 1'b0;
    settle_d   = settle_q;
    aborted_d  = aborted_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_LOAD;
          sh_cnt_d  = '0;
          bit_cnt_d = '0;
          rb_cnt_d  = '0;
          aborted_d = 1'b0;
        end
      end

      S_LOAD: begin
        if (accept) begin
          sh_d     = bus.word_data;
          sh_cnt_d = FULL_CNT;
        end else if (shifting) begin
          sh_d     = sh_q >> 1;
          sh_cnt_d = sh_cnt_q - SH_W'(1);
        end

        if (shifting) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          rb_sh_d   = {bus.chain_data_in, rb_sh_q[WORD_W-2:1]};
          if (rb_cnt_q == RB_LAST) begin
            rb_cnt_d = '0;
            if (!bus.abort) begin
              rb_word_d  = {bus.chain_data_in, rb_sh_q};
              rb_valid_d = 1'b1;
            end
          end else begin
            rb_cnt_d = rb_cnt_q + RB_W'(1);
          end
        end

        if (bus.abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (last_bit) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end

      S_SETTLE: begin
        if (bus.abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (settle_q == ST_LAST) begin
          state_d = S_DONE;
        end else begin
          settle_d = settle_q + ST_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d == S_LOAD) || (state_d == S_SETTLE);
    done_d     = (state_d == S_DONE);
    fab_en_d   = (state_d == S_DONE);
    fab_nrst_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      sh_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      rb_sh_q    <= '0;
      rb_cnt_q   <= '0;
      rb_word_q  <= '0;
      rb_valid_q <= 1'b0;
      settle_q   <= '0;
      aborted_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fab_en_q   <= 1'b0;
      fab_nrst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      sh_cnt_q   <= sh_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      rb_sh_q    <= rb_sh_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_word_q  <= rb_word_d;
      rb_valid_q <= rb_valid_d;
      settle_q   <= settle_d;
      aborted_q  <= aborted_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fab_en_q   <= fab_en_d;
      fab_nrst_q <= fab_nrst_d;
    end
  end

endmodule
